dot_product_accumulator: RTL and testbench

//   Sequential consumer of wallace_tree_signed products. Accepts a stream of signed
//   2*WIDTH-bit products under a valid/ready handshake. Accumulates VEC_LEN of them into
//   a signed ACC_WIDTH-bit saturating accumulator, then presents the dot-product result

---
 rtl/dot_product_accumulator_pkg.sv | 23 ++
 rtl/dot_product_accumulator_sat_add.sv | 29 ++
 rtl/dot_product_accumulator.sv | 141 ++++++++++++++
 tb/tb_dot_product_accumulator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_accumulator_pkg.sv
// Shared types and constants for the dot-product accumulator and its saturating adder.
package dot_product_accumulator_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned DefWidth    = 16;
    localparam int unsigned DefVecLen   = 8;
    localparam int unsigned DefAccWidth = 40;

    // Results are 128 bits wide; callers truncate to their accumulator width.
    function automatic logic [127:0] acc_max(input int unsigned w);
        return (128'd1 << (w - 1)) - 128'd1;
    endfunction

    function automatic logic [127:0] acc_min(input int unsigned w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/dot_product_accumulator_sat_add.sv
// Combinational signed adder that clamps to the representable range on overflow.
module sat_add_signed
    import dot_product_accumulator_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = DefAccWidth
) (
    input  logic [ACC_WIDTH-1:0] a_i,
    input  logic [ACC_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0] sum_o,
    output logic                 ovf_o
);

    localparam logic [ACC_WIDTH-1:0] AccMax = ACC_WIDTH'(acc_max(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] AccMin = ACC_WIDTH'(acc_min(ACC_WIDTH));

    logic [ACC_WIDTH-1:0] sum_raw;

    always_comb begin
        sum_raw = a_i + b_i;
        // Overflow only when both operands share a sign that the sum does not.
        ovf_o   = (a_i[ACC_WIDTH-1] == b_i[ACC_WIDTH-1]) &&
                  (sum_raw[ACC_WIDTH-1] != a_i[ACC_WIDTH-1]);
        sum_o   = sum_raw;
        if (ovf_o) begin
            sum_o = a_i[ACC_WIDTH-1] ? AccMin : AccMax;
        end
    end

endmodule

// File: rtl/dot_product_accumulator.sv
// Accumulates VEC_LEN signed products behind an input register stage and presents the
// saturated dot product under a valid/ready handshake.
module dot_product_accumulator
    import dot_product_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned VEC_LEN   = DefVecLen,
    parameter int unsigned ACC_WIDTH = DefAccWidth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [2*WIDTH-1:0]   prod_in,
    input  logic                 prod_valid,
    output logic                 prod_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic                 acc_ovf
);

    localparam int unsigned     CntW    = $clog2(VEC_LEN + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(VEC_LEN - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(VEC_LEN);

    state_e state_q, state_d;

    logic [CntW-1:0]      count_q, count_d;
    logic                 pipe_valid_q, pipe_valid_d;
    logic                 pipe_last_q, pipe_last_d;
    logic [2*WIDTH-1:0]   pipe_prod_q, pipe_prod_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;

    logic                 accept;
    logic                 res_accept;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic                 sum_ovf;

    assign accept     = prod_valid & prod_ready;
    assign res_accept = acc_valid & acc_ready;
    assign prod_ext   = ACC_WIDTH'($signed(pipe_prod_q));

    sat_add_signed #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_sat_add (
        .a_i  (acc_q),
        .b_i  (prod_ext),
        .sum_o(sum),
        .ovf_o(sum_ovf)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (accept) state_d = StAccum;
                StAccum: if (pipe_valid_q && pipe_last_q) state_d = StDone;
                StDone:  if (res_accept) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        prod_ready = 1'b0;
        acc_valid  = 1'b0;
        unique case (state_q)
            StIdle, StAccum: prod_ready = !rst && !clear && (count_q < FullCnt);
            StDone:          acc_valid  = 1'b1;
            default:         ;
        endcase
    end

    // Datapath next state: input register stage followed by the accumulate stage.
    always_comb begin
        count_d      = count_q;
        pipe_valid_d = 1'b0;
        pipe_last_d  = pipe_last_q;
        pipe_prod_d  = pipe_prod_q;
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        if (clear) begin
            count_d = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (accept) begin
                pipe_valid_d = 1'b1;
                pipe_prod_d  = prod_in;
                pipe_last_d  = (count_q == LastCnt);
                count_d      = count_q + CntW'(1);
            end
            if (pipe_valid_q) begin
                acc_d = sum;
                ovf_d = ovf_q | sum_ovf;
            end
            if (res_accept) begin
                count_d = '0;
                acc_d   = '0;
                ovf_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            pipe_valid_q <= 1'b0;
            pipe_last_q  <= 1'b0;
            pipe_prod_q  <= '0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_last_q  <= pipe_last_d;
            pipe_prod_q  <= pipe_prod_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
        end
    end

    assign acc_out = acc_q;
    assign acc_ovf = ovf_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Randomised bench for dot_product_accumulator: a 40-bit and a 32-bit accumulator share
// one stimulus stream and are both compared against a saturating-sum model.
module tb_dot_product_accumulator;

    localparam int unsigned W   = 16;
    localparam int unsigned VL  = 4;
    localparam int unsigned AW  = 40;
    localparam int unsigned AWN = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [31:0]   prod_in;
    logic          prod_valid;
    logic          acc_ready;

    logic          prod_ready, prod_ready_n;
    logic [AW-1:0] acc_out;
    logic [AWN-1:0] acc_out_n;
    logic          acc_valid, acc_valid_n;
    logic          acc_ovf, acc_ovf_n;

    int checks   = 0;
    int failures = 0;

    logic [31:0] vec_q[$];

    always #5 clk = ~clk;

    dot_product_accumulator #(.WIDTH(W), .VEC_LEN(VL), .ACC_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .prod_in   (prod_in),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_ovf   (acc_ovf)
    );

    dot_product_accumulator #(.WIDTH(W), .VEC_LEN(VL), .ACC_WIDTH(AWN)) dut_n (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .prod_in   (prod_in),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready_n),
        .acc_out   (acc_out_n),
        .acc_valid (acc_valid_n),
        .acc_ready (acc_ready),
        .acc_ovf   (acc_ovf_n)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sum of the vector with clamping after every addition at the given width.
    task automatic model(input int w, output logic [63:0] sum, output logic ovf);
        longint acc = 0;
        longint mx;
        longint mn;
        mx  = (longint'(1) << (w - 1)) - 1;
        mn  = -mx - 1;
        ovf = 1'b0;
        foreach (vec_q[i]) begin
            acc += longint'($signed(vec_q[i]));
            if (acc > mx) begin
                acc = mx;
                ovf = 1'b1;
            end else if (acc < mn) begin
                acc = mn;
                ovf = 1'b1;
            end
        end
        sum = acc;
    endtask

    task automatic send_all(input bit gapped, output bit ok);
        ok = 1'b1;
        foreach (vec_q[i]) begin
            int budget = 0;
            bit done   = 1'b0;
            prod_in    = vec_q[i];
            prod_valid = 1'b1;
            while (!done && budget < 50) begin
                if (prod_ready) done = 1'b1;
                tick();
                budget++;
            end
            prod_valid = 1'b0;
            prod_in    = $urandom;
            if (!done) begin
                check_eq("send_timeout", 64'd0, 64'd1);
                ok = 1'b0;
                return;
            end
            if (gapped && i != vec_q.size() - 1) begin
                tick();
                tick();
            end
        end
    endtask

    task automatic run_vec(input string tag, input bit gapped, input int hold);
        logic [63:0] e40, e32;
        logic        o40, o32;
        bit          ok;
        int          lat;
        logic [AW-1:0] held;
        model(AW, e40, o40);
        model(AWN, e32, o32);
        send_all(gapped, ok);
        if (!ok) return;
        lat = 1;
        while (!acc_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd2);
        check_eq({tag, "_acc40"}, longint'($signed(acc_out)), e40);
        check_eq({tag, "_ovf40"}, 64'(acc_ovf), 64'(o40));
        check_eq({tag, "_valid32"}, 64'(acc_valid_n), 64'd1);
        check_eq({tag, "_acc32"}, longint'($signed(acc_out_n)), e32);
        check_eq({tag, "_ovf32"}, 64'(acc_ovf_n), 64'(o32));
        check_eq({tag, "_ready_in_done"}, 64'(prod_ready), 64'd0);
        held = acc_out;
        repeat (hold) begin
            tick();
            check_eq({tag, "_hold_acc"}, 64'(acc_out), 64'(held));
            check_eq({tag, "_hold_valid"}, 64'(acc_valid), 64'd1);
            check_eq({tag, "_hold_ready"}, 64'(prod_ready), 64'd0);
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        check_eq({tag, "_ready_after"}, 64'(prod_ready), 64'd1);
        check_eq({tag, "_valid_after"}, 64'(acc_valid), 64'd0);
        check_eq({tag, "_ovf_after"}, 64'(acc_ovf_n), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic signed [15:0] a, b;
        logic signed [31:0] p;

        rst        = 1'b1;
        clear      = 1'b0;
        prod_valid = 1'b0;
        prod_in    = '0;
        acc_ready  = 1'b0;
        tick();
        check_eq("rst_ready", 64'(prod_ready), 64'd0);
        tick();
        check_eq("rst_acc", 64'(acc_out), 64'd0);
        check_eq("rst_valid", 64'(acc_valid), 64'd0);
        check_eq("rst_ovf", 64'(acc_ovf), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 64'(prod_ready), 64'd1);

        vec_q = '{32'h9, 32'h9, 32'h9, 32'h9};
        run_vec("t1", 1'b0, 0);
        vec_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h3};
        run_vec("t2", 1'b0, 0);
        vec_q = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
        run_vec("t3_sat", 1'b0, 1);
        vec_q = '{32'h1, 32'h1, 32'h1, 32'h1};
        run_vec("t3_next", 1'b0, 0);
        vec_q = '{32'h5, 32'h6, 32'h7, 32'h8};
        run_vec("t4_bp", 1'b0, 5);

        // Abort a partial vector with clear; the product offered alongside must be dropped.
        vec_q = '{32'h5, 32'h7};
        send_all(1'b0, ok);
        clear      = 1'b1;
        prod_in    = 32'd99;
        prod_valid = 1'b1;
        #1;
        check_eq("clr_ready", 64'(prod_ready), 64'd0);
        tick();
        clear      = 1'b0;
        prod_valid = 1'b0;
        #1;
        check_eq("clr_acc", 64'(acc_out), 64'd0);
        check_eq("clr_ready_after", 64'(prod_ready), 64'd1);
        vec_q = '{32'h1, 32'h2, 32'h3, 32'h4};
        run_vec("t5_clear", 1'b0, 0);

        vec_q = '{32'h5, 32'h7};
        send_all(1'b0, ok);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_ready", 64'(prod_ready), 64'd0);
        tick();
        check_eq("rst_mid_acc", 64'(acc_out), 64'd0);
        check_eq("rst_mid_valid", 64'(acc_valid), 64'd0);
        rst = 1'b0;
        #1;
        vec_q = '{32'h1, 32'h2, 32'h3, 32'h4};
        run_vec("t5_rst", 1'b0, 0);

        // clear while a result is pending discards it.
        vec_q = '{32'h1, 32'h1, 32'h1, 32'h1};
        send_all(1'b0, ok);
        tick();
        check_eq("done_valid", 64'(acc_valid), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        check_eq("done_clr_valid", 64'(acc_valid), 64'd0);
        check_eq("done_clr_acc", 64'(acc_out), 64'd0);
        check_eq("done_clr_ready", 64'(prod_ready), 64'd1);

        for (int v = 0; v < 10; v++) begin
            vec_q = {};
            for (int k = 0; k < VL; k++) begin
                if (v[0]) begin
                    a = $urandom_range(0, 1) ? 16'sh8000 : 16'sh7FFF;
                    b = $urandom_range(0, 1) ? 16'sh8000 : 16'sh7FFF;
                end else begin
                    a = 16'($urandom);
                    b = 16'($urandom);
                end
                p = a * b;
                vec_q.push_back(p);
            end
            run_vec($sformatf("t6_%0d", v), 1'b1, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
